// File: rtl/circle_top.sv
// ---------------------------------------------------------------------------
// circle_top -- Bresenham circle-drawing accelerator for the 160x120, 3-bit
// colour VGA adapter pixel interface.
//
// A 1->0 edge on the synchronised start key (KEY_N[3]) launches one run. The
// run plots a single circle outline centred on (XC, YC) with radius RADIUS,
// writing one pixel per clock. It then waits in DONE for the next start. A
// start seen mid-run aborts the run and begins a new one.
//
// Optional feature (macro CLEAR_SCREEN_EN):
//   defined   : each run first clears the frame to black with a 160x120
//               raster scan, then draws the circle.
//   undefined : no clear. Existing frame content is kept, and the FSM goes
//               straight to INIT.
//
// Ports:
//   CLOCK_50    in   1  system clock, rising edge
//   RESET       in   1  asynchronous, active-high reset
//   KEY_N       in   4  active-low keys: [3]=start, [0]=colour select
//   x           out  8  live Bresenham x offset
//   y           out  7  live Bresenham y offset
//   vga_x       out  8  pixel column (registered)
//   vga_y       out  7  pixel row (registered)
//   vga_plot    out  1  write strobe (registered)
//   vga_colour  out  3  pixel colour (registered)
// ---------------------------------------------------------------------------
module circle_top #(
    parameter int         XC     = 80,
    parameter int         YC     = 60,
    parameter int         RADIUS = 40,
    parameter logic [2:0] COLOUR = 3'b111
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY_N,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic       vga_plot,
    output logic [2:0] vga_colour
);
    typedef enum logic [2:0] {IDLE, CLEAR, INIT, DRAW, DONE} state_t;

    localparam logic signed [9:0] XC_S = 10'(XC);
    localparam logic signed [9:0] YC_S = 10'(YC);

    state_t            state, state_n;
    logic              start_s1, start_s2, start_s3, col_s1, col_s2, start;
    logic [2:0]        oct, oct_n;
    logic signed [7:0] ox, ox_n, oy, oy_n, oy_inc, ox_dec;
    logic signed [9:0] crit, crit_n, ox_w, oy_w, oy_inc_w, ox_dec_w, px, py;
    logic [2:0]        colour, colour_n, vc_n;
    logic [7:0]        vx_n;
    logic [6:0]        vy_n;
    logic              plot_n, on_screen;
    logic              unused_keys;

`ifdef CLEAR_SCREEN_EN
    logic [7:0] clr_x, clr_x_n;
    logic [6:0] clr_y, clr_y_n;
`endif

    assign unused_keys = &{1'b0, KEY_N[2:1]};
    assign x = ox;
    assign y = oy[6:0];

    // Key synchronisers. They reset to 1 (released) so that leaving reset
    // never looks like a press.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            start_s1 <= 1'b1;
            start_s2 <= 1'b1;
            start_s3 <= 1'b1;
            col_s1   <= 1'b1;
            col_s2   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            start_s1 <= KEY_N[3];
            start_s2 <= start_s1;
            start_s3 <= start_s2;
            col_s1   <= KEY_N[0];
            col_s2   <= col_s1;
        end
    end

    // One-cycle pulse on the falling edge of the synchronised start key.
    assign start = start_s3 & ~start_s2;

    // Octant point generator. The computation is signed so that points to
    // the left of or above the screen come out negative and get clipped.
    always_comb begin
        ox_w = 10'(ox);
        oy_w = 10'(oy);
        case (oct)
            3'd0:    begin px = XC_S + ox_w; py = YC_S + oy_w; end
            3'd1:    begin px = XC_S + oy_w; py = YC_S + ox_w; end
            3'd2:    begin px = XC_S - ox_w; py = YC_S + oy_w; end
            3'd3:    begin px = XC_S - oy_w; py = YC_S + ox_w; end
            3'd4:    begin px = XC_S - ox_w; py = YC_S - oy_w; end
            3'd5:    begin px = XC_S - oy_w; py = YC_S - ox_w; end
            3'd6:    begin px = XC_S + ox_w; py = YC_S - oy_w; end
            default: begin px = XC_S + oy_w; py = YC_S - ox_w; end
        endcase
        on_screen = (px >= 10'sd0) && (px <= 10'sd159) &&
                    (py >= 10'sd0) && (py <= 10'sd119);
        oy_inc   = oy + 8'sd1;
        ox_dec   = ox - 8'sd1;
        oy_inc_w = 10'(oy_inc);
        ox_dec_w = 10'(ox_dec);
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_n  = state;
        oct_n    = oct;
        ox_n     = ox;
        oy_n     = oy;
        crit_n   = crit;
        colour_n = colour;
        plot_n   = 1'b0;
        vx_n     = '0;
        vy_n     = '0;
        vc_n     = '0;
`ifdef CLEAR_SCREEN_EN
        clr_x_n  = clr_x;
        clr_y_n  = clr_y;
`endif
        case (state)
`ifdef CLEAR_SCREEN_EN
            CLEAR: begin
                plot_n = 1'b1;
                vx_n   = clr_x;
                vy_n   = clr_y;
                if (clr_x == 8'd159) begin
                    clr_x_n = '0;
                    if (clr_y == 7'd119) begin
                        clr_y_n = '0;
                        state_n = INIT;
                    end else begin
                        clr_y_n = clr_y + 7'd1;
                    end
                end else begin
                    clr_x_n = clr_x + 8'd1;
                end
            end
`endif
            INIT: begin
                ox_n    = 8'(RADIUS);
                oy_n    = '0;
                crit_n  = 10'(1 - RADIUS);
                oct_n   = '0;
                state_n = DRAW;
            end
            DRAW: begin
                plot_n = on_screen;
                vx_n   = px[7:0];
                vy_n   = py[6:0];
                vc_n   = colour;
                oct_n  = oct + 3'd1;
                // The Bresenham step happens on the cycle of the 8th point.
                if (oct == 3'd7) begin
                    oy_n = oy_inc;
                    if (crit <= 10'sd0) begin
                        crit_n = crit + (oy_inc_w <<< 1) + 10'sd1;
                        if (oy_inc > ox) state_n = DONE;
                    end else begin
                        ox_n   = ox_dec;
                        crit_n = crit + ((oy_inc_w - ox_dec_w) <<< 1) + 10'sd1;
                        if (oy_inc > ox_dec) state_n = DONE;
                    end
                end
            end
            default: ;
        endcase

        // A start overrides whatever the FSM was doing, from any state.
        if (start) begin
            colour_n = col_s2 ? 3'b100 : COLOUR;
`ifdef CLEAR_SCREEN_EN
            state_n  = CLEAR;
            clr_x_n  = '0;
            clr_y_n  = '0;
`else
            state_n  = INIT;
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            oct        <= '0;
            ox         <= '0;
            oy         <= '0;
            crit       <= '0;
            colour     <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_plot   <= 1'b0;
            vga_colour <= '0;
`ifdef CLEAR_SCREEN_EN
            clr_x      <= '0;
            clr_y      <= '0;
`endif
        end else begin
            state      <= state_n;
            oct        <= oct_n;
            ox         <= ox_n;
            oy         <= oy_n;
            crit       <= crit_n;
            colour     <= colour_n;
            vga_x      <= vx_n;
            vga_y      <= vy_n;
            vga_plot   <= plot_n;
            vga_colour <= vc_n;
`ifdef CLEAR_SCREEN_EN
            clr_x      <= clr_x_n;
            clr_y      <= clr_y_n;
`endif
        end
    end
endmodule

// File: tb/tb_circle_top.sv
// ---------------------------------------------------------------------------
// tb_circle_top -- self-checking bench for circle_top.
//
// Three instances share the clock, reset and keys:
//   u0 : defaults (80,60), radius 40
//   u1 : centre (150,60), radius 20, so part of the circle is clipped
//   u2 : radius 0, colour 3'b010
// A reference model produces the expected per-cycle plot stream from the
// Bresenham rules. Captured outputs are compared against that stream, against
// a hand-computed vector table, and against geometric properties.
// ---------------------------------------------------------------------------
module tb_circle_top;
    localparam int TAIL = 40;
`ifdef CLEAR_SCREEN_EN
    localparam int NCLR = 19200;
`else
    localparam int NCLR = 0;
`endif
    localparam int BASE = 4 + NCLR;   // capture index of the first DRAW slot

    localparam int P_XC  [3] = '{80, 150, 80};
    localparam int P_YC  [3] = '{60, 60, 60};
    localparam int P_R   [3] = '{40, 20, 0};
    localparam int P_COL [3] = '{7, 7, 2};
    localparam int SGX   [8] = '{1, 1, -1, -1, -1, -1, 1, 1};
    localparam int SGY   [8] = '{1, 1, 1, 1, -1, -1, -1, -1};
    localparam int SWP   [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    typedef struct { bit plot; int vx; int vy; int col; } obs_t;
    typedef struct { int d; int slot; bit plot; int vx; int vy; int col; } vec_t;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic [3:0] KEY_N;
    logic [7:0] x_o   [3];
    logic [6:0] y_o   [3];
    logic [7:0] vx_o  [3];
    logic [6:0] vy_o  [3];
    logic       plot_o[3];
    logic [2:0] col_o [3];

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t cap  [3][$];
    obs_t expq [3][$];
    int   exp_fx [3];
    int   exp_fy [3];

    always #10 CLOCK_50 = ~CLOCK_50;

    circle_top u0 (.CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_N(KEY_N),
                   .x(x_o[0]), .y(y_o[0]), .vga_x(vx_o[0]), .vga_y(vy_o[0]),
                   .vga_plot(plot_o[0]), .vga_colour(col_o[0]));
    circle_top #(.XC(150), .YC(60), .RADIUS(20), .COLOUR(3'b111)) u1 (
                   .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_N(KEY_N),
                   .x(x_o[1]), .y(y_o[1]), .vga_x(vx_o[1]), .vga_y(vy_o[1]),
                   .vga_plot(plot_o[1]), .vga_colour(col_o[1]));
    circle_top #(.XC(80), .YC(60), .RADIUS(0), .COLOUR(3'b010)) u2 (
                   .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_N(KEY_N),
                   .x(x_o[2]), .y(y_o[2]), .vga_x(vx_o[2]), .vga_y(vy_o[2]),
                   .vga_plot(plot_o[2]), .vga_colour(col_o[2]));

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic obs_t mk(input bit p, input int vx, input int vy, input int c);
        obs_t o;
        o.plot = p; o.vx = vx; o.vy = vy; o.col = c;
        return o;
    endfunction

    // Coordinates only matter when a pixel is actually written.
    function automatic int pack(input obs_t o);
        return o.plot ? ((1 << 20) | ((o.vx & 255) << 12) | ((o.vy & 127) << 4) | (o.col & 7)) : 0;
    endfunction

    // Reference model: the complete DRAW slot stream, clipped slots included.
    function automatic void build_model(input int d, input int xc, input int yc,
                                        input int r, input int col);
        int ox, oy, crit, a, b, px, py;
        expq[d].delete();
        ox = r; oy = 0; crit = 1 - r;
        do begin
            for (int k = 0; k < 8; k++) begin
                a  = (SWP[k] != 0) ? oy : ox;
                b  = (SWP[k] != 0) ? ox : oy;
                px = xc + SGX[k] * a;
                py = yc + SGY[k] * b;
                expq[d].push_back(mk(px >= 0 && px < 160 && py >= 0 && py < 120, px, py, col));
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
        exp_fx[d] = ox;
        exp_fy[d] = oy;
    endfunction

    task automatic capture(input int n);
        obs_t o;
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            for (int d = 0; d < 3; d++) begin
                o = mk(plot_o[d], int'(vx_o[d]), int'(vy_o[d]), int'(col_o[d]));
                cap[d].push_back(o);
            end
        end
    endtask

    // Holds KEY_N[3] low for one clock. Capture index 0 is the first negedge
    // after the key goes low.
    task automatic press(input bit csel);
        @(negedge CLOCK_50);
        KEY_N[0] = csel;
        KEY_N[3] = 1'b0;
        for (int d = 0; d < 3; d++) cap[d].delete();
        capture(1);
        KEY_N[3] = 1'b1;
    endtask

    task automatic verify_stream(input int d, input string tag);
        obs_t e;
        int   n;
        n = expq[d].size();
        for (int k = 0; k < n + TAIL; k++) begin
            e = (k < n) ? expq[d][k] : mk(1'b0, 0, 0, 0);
            if (BASE + k >= cap[d].size())
                check($sformatf("%s_d%0d_slot%0d_missing", tag, d, k), -1, pack(e));
            else
                check($sformatf("%s_d%0d_slot%0d", tag, d, k), pack(cap[d][BASE + k]), pack(e));
        end
    endtask

`ifdef CLEAR_SCREEN_EN
    task automatic verify_clear(input string tag);
        obs_t o;
        int   bad, cnt;
        bad = 0;
        cnt = 0;
        for (int i = 0; i < 19200; i++) begin
            o = cap[0][3 + i];
            if (!(o.plot && o.vx == i % 160 && o.vy == i / 160 && o.col == 0)) bad++;
        end
        for (int i = 0; i < BASE; i++) if (cap[0][i].plot && cap[0][i].col == 0) cnt++;
        check({tag, "_clear_raster_errors"}, bad, 0);
        check({tag, "_clear_plot_count"}, cnt, 19200);
        check({tag, "_clear_first"}, pack(cap[0][3]), pack(mk(1'b1, 0, 0, 0)));
        check({tag, "_clear_last"}, pack(cap[0][3 + 19199]), pack(mk(1'b1, 159, 119, 0)));
    endtask
`endif

    task automatic run_full(input bit csel, input bit lead, input string tag);
        int maxlen, lead_plots, hi_x;
        maxlen = 0;
        for (int d = 0; d < 3; d++) begin
            build_model(d, P_XC[d], P_YC[d], P_R[d], csel ? 4 : P_COL[d]);
            if (expq[d].size() > maxlen) maxlen = expq[d].size();
        end
        press(csel);
        capture(3 + NCLR + maxlen + TAIL);
        for (int d = 0; d < 3; d++) begin
            if (lead) begin
                lead_plots = 0;
                for (int i = 0; i < 3; i++) if (cap[d][i].plot) lead_plots++;
                check($sformatf("%s_d%0d_idle_before_start", tag, d), lead_plots, 0);
            end
            check($sformatf("%s_d%0d_init_cycle_plot", tag, d), int'(cap[d][BASE - 1].plot), 0);
            verify_stream(d, tag);
        end
`ifdef CLEAR_SCREEN_EN
        verify_clear(tag);
`endif
        hi_x = 0;
        foreach (cap[1][i]) if (cap[1][i].plot && cap[1][i].vx > 159) hi_x++;
        check({tag, "_clip_x_over_159"}, hi_x, 0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_final_x", tag, d), int'(x_o[d]), exp_fx[d]);
            check($sformatf("%s_d%0d_final_y", tag, d), int'(y_o[d]), exp_fy[d]);
        end
    endtask

    task automatic circle_props();
        bit seen [int];
        int bad_r, bad_s, dx, dy, e, a, b;
        obs_t o;
        bad_r = 0;
        bad_s = 0;
        for (int k = 0; k < expq[0].size(); k++) begin
            o = cap[0][BASE + k];
            if (o.plot) seen[o.vx * 256 + o.vy] = 1'b1;
        end
        foreach (seen[key]) begin
            dx = key / 256 - 80;
            dy = key % 256 - 60;
            e  = dx * dx + dy * dy - 1600;
            if (e < 0) e = -e;
            if (e >= 80) bad_r++;
            for (int s = 0; s < 8; s++) begin
                a = s[2] ? dy : dx;
                b = s[2] ? dx : dy;
                if (s[0]) a = -a;
                if (s[1]) b = -b;
                if (!seen.exists((80 + a) * 256 + 60 + b)) bad_s++;
            end
        end
        check("radius_error_points", bad_r, 0);
        check("symmetry_misses", bad_s, 0);
        check("circle_has_points", int'(seen.num() > 0), 1);
    endtask

    initial begin
        vec_t vt [16];
        int   plots, m;
        bit   csel;

        // Hand-computed DRAW slots for the first run (KEY_N[0]=0).
        vt[0]  = '{0, 0, 1'b1, 120, 60, 7};
        vt[1]  = '{0, 1, 1'b1, 80, 100, 7};
        vt[2]  = '{0, 2, 1'b1, 40, 60, 7};
        vt[3]  = '{0, 5, 1'b1, 80, 20, 7};
        vt[4]  = '{0, 7, 1'b1, 80, 20, 7};
        vt[5]  = '{0, 8, 1'b1, 120, 61, 7};
        vt[6]  = '{1, 0, 1'b0, 0, 0, 0};
        vt[7]  = '{1, 1, 1'b1, 150, 80, 7};
        vt[8]  = '{1, 2, 1'b1, 130, 60, 7};
        vt[9]  = '{1, 5, 1'b1, 150, 40, 7};
        vt[10] = '{1, 6, 1'b0, 0, 0, 0};
        vt[11] = '{1, 8, 1'b0, 0, 0, 0};
        vt[12] = '{1, 9, 1'b1, 151, 80, 7};
        vt[13] = '{2, 0, 1'b1, 80, 60, 2};
        vt[14] = '{2, 7, 1'b1, 80, 60, 2};
        vt[15] = '{2, 8, 1'b0, 0, 0, 0};

        RESET = 1'b1;
        KEY_N = 4'hF;
        repeat (3) @(negedge CLOCK_50);
        check("reset_x", int'(x_o[0]), 0);
        check("reset_y", int'(y_o[0]), 0);
        check("reset_vga_x", int'(vx_o[0]), 0);
        check("reset_vga_y", int'(vy_o[0]), 0);
        check("reset_vga_plot", int'(plot_o[0]), 0);
        check("reset_vga_colour", int'(col_o[0]), 0);
        RESET = 1'b0;
        for (int d = 0; d < 3; d++) cap[d].delete();
        capture(100);
        plots = 0;
        for (int d = 0; d < 3; d++) foreach (cap[d][i]) if (cap[d][i].plot) plots++;
        check("no_plot_without_start", plots, 0);

        run_full(1'b0, 1'b1, "run1");
        for (int i = 0; i < 16; i++)
            check($sformatf("vec%0d_d%0d_slot%0d", i, vt[i].d, vt[i].slot),
                  pack(cap[vt[i].d][BASE + vt[i].slot]),
                  pack(mk(vt[i].plot, vt[i].vx, vt[i].vy, vt[i].col)));
        circle_props();

`ifndef CLEAR_SCREEN_EN
        run_full(1'b1, 1'b1, "colour1");
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(5, 30)) @(negedge CLOCK_50);
            csel = 1'($urandom_range(0, 1));
            run_full(csel, 1'b1, $sformatf("rand%0d", r));
        end
`endif

        // Restart: second press at a random point inside DRAW, KEY_N[0]=1.
        m = 3 + NCLR + $urandom_range(0, 150);
        press(1'($urandom_range(0, 1)));
        capture(m);
        run_full(1'b1, 1'b0, "restart");

        // Reset in the middle of a run.
        press(1'b0);
        capture((NCLR > 0) ? 100 : 10);
        check("plotting_before_reset", int'(plot_o[0]), 1);
        #3 RESET = 1'b1;
        #1;
        check("reset_mid_vga_plot", int'(plot_o[0]), 0);
        check("reset_mid_x", int'(x_o[0]), 0);
        check("reset_mid_vga_x", int'(vx_o[0]), 0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        for (int d = 0; d < 3; d++) cap[d].delete();
        capture(60);
        plots = 0;
        for (int d = 0; d < 3; d++) foreach (cap[d][i]) if (cap[d][i].plot) plots++;
        check("idle_after_reset", plots, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/circle_top.md
Name: circle_top

Overview:
- Bresenham circle-drawing accelerator for the 160x120, 3-bit-colour VGA adapter pixel interface.
- On a start key press it clears the frame to black, then plots one circle outline, one pixel per clock, and waits for the next press.
- Sits between the board keys/clock and the VGA adapter core.

Parameters:
- XC, 80, circle centre x (0..159)
- YC, 60, circle centre y (0..119)
- RADIUS, 40, circle radius in pixels (0..63)
- COLOUR, 3'b111, circle colour when KEY_N[0] is pressed

Ports:
- CLOCK_50  input  1  system clock; all logic on the rising edge
- RESET  input  1  asynchronous, active-high reset
- KEY_N  input  4  active-low push buttons; [3]=start, [0]=colour select, [2:1] unused
- x  output  8  current Bresenham x offset (offset_x), zero-extended
- y  output  7  current Bresenham y offset (offset_y), zero-extended
- vga_x  output  8  pixel column to write (0..159)
- vga_y  output  7  pixel row to write (0..119)
- vga_plot  output  1  write strobe; pixel is written on the clock edge where it is 1
- vga_colour  output  3  pixel colour

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; key synchronisers forced to 1 (released).
- Key inputs: KEY_N[3] passes through a 2-flop synchroniser. A start is the 1->0 edge of the synchronised signal. KEY_N[0] is synchronised and sampled at start: 0 selects COLOUR, 1 selects 3'b100.
- FSM states: IDLE, CLEAR, INIT, DRAW, DONE.
- IDLE/DONE -> CLEAR on start.
- CLEAR:
  - Raster scan with x 0..159 inner and y 0..119 outer.
  - vga_colour=0 and vga_plot=1 on each of 19200 consecutive cycles.
  - After (159,119), go to INIT.
- INIT (1 cycle, vga_plot=0):
  - offset_x=RADIUS, offset_y=0, crit=1-RADIUS.
  - crit is signed and at least 9 bits wide.
- DRAW: the 8 octant points are plotted on 8 consecutive cycles, in this order:
  - (XC+ox, YC+oy), (XC+oy, YC+ox), (XC-ox, YC+oy), (XC-oy, YC+ox), (XC-ox, YC-oy), (XC-oy, YC-ox), (XC+ox, YC-oy), (XC+oy, YC-ox).
  - On the cycle of the 8th point, the Bresenham state updates:
    - oy+=1.
    - If crit<=0: crit+=2*oy_new+1.
    - Otherwise: ox-=1 and crit+=2*(oy_new-ox_new)+1.
  - DRAW loops while oy<=ox, then goes to DONE.
- Clipping: a point with computed x outside 0..159 or y outside 0..119 (signed arithmetic) still takes its cycle, but with vga_plot=0.
- Outputs: vga_x, vga_y, vga_plot and vga_colour are registered and valid together in the same cycle. x and y show the live offset_x and offset_y.
- IDLE and DONE: vga_plot=0.
- Start during CLEAR/INIT/DRAW aborts and restarts at CLEAR pixel (0,0) on the next cycle.
- RESET mid-operation: immediate return to IDLE, outputs zeroed.
- RADIUS=0: a single centre pixel plotted 8 times.

Optional Feature:
- Macro CLEAR_SCREEN_EN.
- When defined: a start runs CLEAR before INIT, as described above.
- When undefined: the CLEAR state is omitted. A start goes directly to INIT, existing frame content is preserved, and circle plotting begins 2 cycles after the start edge.

Test Plan:
- Reset: assert RESET with CLOCK_50 running -> all outputs 0; no vga_plot for 100 cycles without a start.
- Clear: pulse KEY_N[3] low for 1 cycle -> exactly 19200 vga_plot cycles with vga_colour=0. The first is (0,0), the last is (159,119), and they are contiguous in raster order.
- Circle defaults (RADIUS=40, KEY_N[0]=0):
  - The first DRAW plot is (120,60) with colour 3'b111.
  - The second DRAW plot is (80,100).
  - All plotted points satisfy |dx^2+dy^2-1600| < 2*40.
  - The point set is 8-way symmetric about (80,60).
  - DONE is reached and vga_plot stays 0 afterwards.
- Clipping: XC=150, RADIUS=20 -> no plot with vga_x>159; plotted points are the on-screen subset of the unclipped run.
- Restart: second KEY_N[3] press during DRAW -> the next plot is clear pixel (0,0) and the full sequence repeats. A RESET pulse mid-CLEAR -> vga_plot=0 immediately and the FSM stays IDLE.
- Colour select: KEY_N[0]=1 at start -> circle pixels have vga_colour=3'b100.
